sh7034_sci_xfer_ctrl: RTL and testbench
=======================================

// Module: sh7034_sci_xfer_ctrl
// PURPOSE
//  Bus-master sequencer that runs one SH7034 SCI channel autonomously: initialises SMR/BRR/SCR, moves
//  bytes from a TX FIFO into TDR and from RDR into an RX FIFO, and clears SSR flags using the SCI's
//  read-then-write-0 protocol. Sits beside the SCI on the internal register bus and consumes its IRQ lines.
// PARAMETERS
//  N        0      SCI channel; register base = 28'h5FFFEC0 + N*8
//  DEPTH    8      entries per FIFO (power of 2, >=2)
//  SMR_VAL  8'h00  value written to SMR at init (async 8N1, CKS=0)
//  BRR_VAL  8'h00  value written to BRR at init
// PORTS
//  CLK        in   1   system clock
//  RST_N      in   1   asynchronous active-low reset
//  CE_R/CE_F  in   1   rising/falling clock enables; all state advances on CE_R only
//  EN         in   1   1 = run; 0 = stop after current access, return to OFF
//  TX_DATA    in   8   byte to push;  TX_PUSH in 1 (ignored when TX_FULL)
//  TX_FULL    out  1   TX FIFO full;  TX_EMPTY out 1
//  RX_DATA    out  8   head of RX FIFO (valid when !RX_EMPTY); RX_POP in 1 (ignored when empty)
//  RX_EMPTY   out  1   RX FIFO empty
//  ERR        out  3   sticky {ORER,FER,PER} seen; ERR_CLR in 1 clears (set wins on same CE_R)
//  BUSY       out  1   state != IDLE/OFF
//  IBUS_A     out  28  register address;  IBUS_DO out 32 write data;  IBUS_BA out 4 byte lanes
//  IBUS_WE    out  1   write strobe;  IBUS_REQ out 1 access request;  IBUS_DI in 32 read data
//  TXI_IRQ/RXI_IRQ/ERI_IRQ  in 1  SCI interrupt outputs (SCR enables set by this block)
// BEHAVIOUR
//  Reset: IBUS_REQ/WE=0, A/DO/BA=0, ERR=0, BUSY=0, FIFOs empty, state OFF, TX_FIRST=0.
//  Bus access = exactly one CE_R window: outputs registered at CE_R k, REQ=1 for that window; writes
//   land and read data (IBUS_DI) is sampled at CE_R k+1, REQ dropped there. No BUSY handshake.
//  Lanes: SMR DO[31:24] BA=1000, BRR [23:16] 0100, SCR [15:8] 0010, TDR [7:0] 0001,
//   SSR [31:24] 1000; reads take byte from DI[31:24] (SCI replicates on all lanes).
//  FSM: OFF -EN-> INIT_SMR -> INIT_BRR -> INIT_SCR(8'hF0: TIE,RIE,TE,RE) -> IDLE, TX_FIRST<=1.
//   IDLE priority: ERI_IRQ -> E_RD; else RXI_IRQ && !RX_FULL -> R_RD; else !TX_EMPTY &&
//   (TXI_IRQ||TX_FIRST) -> T_RD; else stay. !EN in IDLE -> OFF (SCR not rewritten).
//   T_RD: read SSR; TDRE=1 -> T_WR (write TDR=FIFO head, pop) -> T_CLR (SSR<=8'h7E) -> IDLE,
//     TX_FIRST<=0; TDRE=0 -> IDLE, nothing popped.
//   R_RD: read SSR; RDRF=1 -> R_DAT (read RDR, push RX FIFO) -> R_CLR (SSR<=8'hBE) -> IDLE; else IDLE.
//   E_RD: read SSR; ERR|=SSR[29:27]; -> E_CLR (SSR<=8'hC6) -> IDLE.
//  RX FIFO full: RXI not serviced; SCI overruns, ERI path records ORER; no byte lost from FIFO.
//  Same-cycle TX_PUSH+pop, RX_POP+push: both take effect; counts unchanged; full/empty exact.
//  FIFO pointers log2(DEPTH) bits wrap modulo DEPTH; count log2(DEPTH)+1 bits.
//  EN falling mid-sequence: current access completes, remaining steps abandoned, -> OFF;
//   popped TX byte already written to TDR is not re-queued. RST_N mid-access: REQ drops at once.
//  Sequence length fixed: TX/RX service 3 accesses (+1 IDLE window) -> 4 CE_R per byte max.
// STRUCTURE
//  Package SH7034_PKG: SCI offsets (SMR..RDR = 0..5), SSR bit indices, SSR clear constants
//   (7E/BE/C6), SCXC_STATE_t enum.
//  Sub-module sh7034_sci_fifo (#WIDTH=8, DEPTH): sync FIFO, CE-gated, instanced twice (TX, RX).
// TESTING
//  Init: EN=1 after reset -> writes A=5FFFEC0/EC1/EC2 with DO[15:8]=F0 on 3 consecutive CE_R.
//  TX: push 55,AA; SCI loopback RXD=TXD -> TDR written 55 then AA, each followed by SSR write 7E; TX_EMPTY=1.
//  RX: SCI receives 8'h3C -> RX_EMPTY falls, RX_DATA=3C, SSR write BE seen, RDRF=0 after.
//  Overrun: RX FIFO full, two more frames -> no RDR read, ERR=3'b100 after E_CLR, SSR ORER cleared.
//  Priority: ERI,RXI and pending TX same cycle -> order E_RD, R_RD, T_RD.
//  Abort: EN=0 during T_WR -> TDR write completes, no SSR write, state OFF, BUSY=0 next CE_R.

Source files
------------

// File: rtl/sh7034_sci_xfer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sh7034_sci_xfer_ctrl_pkg
//   Shared definitions for the SH7034 SCI transfer controller:
//   - SCI register offsets from the channel base (SMR..RDR = 0..5)
//   - SSR flag bit positions and the flag-clear values written back to SSR
//   - controller state encoding
//   - ibus_acc_t plus a helper that places a byte on the lane matching its
//     register offset (big-endian lanes: offset 0 -> [31:24], BA 1000)
// ---------------------------------------------------------------------------
package sh7034_sci_xfer_ctrl_pkg;

  localparam logic [27:0] SCI_BASE = 28'h5FFFEC0;

  localparam logic [2:0] OFS_SMR = 3'd0;
  localparam logic [2:0] OFS_BRR = 3'd1;
  localparam logic [2:0] OFS_SCR = 3'd2;
  localparam logic [2:0] OFS_TDR = 3'd3;
  localparam logic [2:0] OFS_SSR = 3'd4;
  localparam logic [2:0] OFS_RDR = 3'd5;

  localparam int SSR_TDRE = 7;
  localparam int SSR_RDRF = 6;
  localparam int SSR_ORER = 5;
  localparam int SSR_FER  = 4;
  localparam int SSR_PER  = 3;

  // Writing 0 to a flag clears it (after it has been read as 1); 1s leave
  // the other flags untouched.
  localparam logic [7:0] SSR_CLR_TX  = 8'h7E;  // clears TDRE
  localparam logic [7:0] SSR_CLR_RX  = 8'hBE;  // clears RDRF
  localparam logic [7:0] SSR_CLR_ERR = 8'hC6;  // clears ORER/FER/PER

  // TIE, RIE, TE, RE
  localparam logic [7:0] SCR_RUN = 8'hF0;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_INIT_SMR,
    ST_INIT_BRR,
    ST_INIT_SCR,
    ST_IDLE,
    ST_T_RD,
    ST_T_WR,
    ST_T_CLR,
    ST_R_RD,
    ST_R_DAT,
    ST_R_CLR,
    ST_E_RD,
    ST_E_CLR
  } scxc_state_t;

  typedef struct packed {
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  lanes;
    logic        we;
  } ibus_acc_t;

  // Build one register access; only the lane of the addressed byte carries data.
  function automatic ibus_acc_t sci_access(input logic [27:0] base,
                                           input logic [2:0]  ofs,
                                           input logic        we,
                                           input logic [7:0]  val);
    ibus_acc_t acc;
    acc.addr  = base + {25'd0, ofs};
    acc.lanes = 4'b1000 >> ofs[1:0];
    acc.wdata = we ? ({val, 24'd0} >> {ofs[1:0], 3'b000}) : 32'd0;
    acc.we    = we;
    return acc;
  endfunction

endpackage

// File: rtl/sh7034_sci_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// sh7034_sci_xfer_ctrl_if
//   Internal register bus plus SCI interrupt lines between the transfer
//   controller (master) and the SCI channel (slave).
//   IBUS_A   28  register address        IBUS_DO 32  write data
//   IBUS_BA   4  byte lanes              IBUS_WE  1  write strobe
//   IBUS_REQ  1  access request          IBUS_DI 32  read data
//   TXI_IRQ / RXI_IRQ / ERI_IRQ          SCI interrupt outputs
// ---------------------------------------------------------------------------
interface sh7034_sci_xfer_ctrl_if;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic [31:0] IBUS_DI;
  logic        TXI_IRQ;
  logic        RXI_IRQ;
  logic        ERI_IRQ;

  modport master (
    output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DI, TXI_IRQ, RXI_IRQ, ERI_IRQ
  );

  modport slave (
    input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DI, TXI_IRQ, RXI_IRQ, ERI_IRQ
  );
endinterface

// File: rtl/sh7034_sci_fifo.sv
// ---------------------------------------------------------------------------
// sh7034_sci_fifo
//   Synchronous first-word-fall-through FIFO, advancing only when CE is high.
//   CLK, RST_N (async, active low), CE   clocking
//   PUSH/WDATA   write (ignored when FULL)
//   POP/RDATA    read; RDATA is the head entry, valid while !EMPTY
//                (ignored when EMPTY)
//   FULL/EMPTY   exact occupancy flags
//   A push and a pop on the same enabled edge both take effect.
// ---------------------------------------------------------------------------
module sh7034_sci_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             PUSH,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             POP,
  output logic [WIDTH-1:0] RDATA,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign FULL    = (count_reg == (AW+1)'(DEPTH));
  assign EMPTY   = (count_reg == '0);
  assign do_push = CE & PUSH & ~FULL;
  assign do_pop  = CE & POP & ~EMPTY;
  assign RDATA   = mem[rd_ptr_reg];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sh7034_sci_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// sh7034_sci_xfer_ctrl
//   Bus-master sequencer for one SH7034 SCI channel: initialises SMR/BRR/SCR,
//   moves bytes TX FIFO -> TDR and RDR -> RX FIFO, and clears SSR flags with
//   the read-then-write-0 protocol.
//   CLK, RST_N (async, active low); CE_R advances all state; CE_F unused.
//   EN        1 = run, 0 = finish current access then go OFF
//   TX_DATA/TX_PUSH, TX_FULL/TX_EMPTY     TX FIFO write side
//   RX_DATA/RX_POP, RX_EMPTY              RX FIFO read side
//   ERR/ERR_CLR  sticky {ORER,FER,PER}; a new error wins over a clear
//   BUSY         controller is in a service or init sequence
//   bus          register bus + IRQ lines (master side)
//   Every bus access occupies exactly one CE_R window: the request is
//   registered on one CE_R and completes (write lands / read sampled) on the
//   next, where the following access, if any, is registered.
// ---------------------------------------------------------------------------
module sh7034_sci_xfer_ctrl
  import sh7034_sci_xfer_ctrl_pkg::*;
#(
  parameter int         N       = 0,
  parameter int         DEPTH   = 8,
  parameter logic [7:0] SMR_VAL = 8'h00,
  parameter logic [7:0] BRR_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       CE_F,
  input  logic       EN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_PUSH,
  output logic       TX_FULL,
  output logic       TX_EMPTY,
  output logic [7:0] RX_DATA,
  input  logic       RX_POP,
  output logic       RX_EMPTY,
  output logic [2:0] ERR,
  input  logic       ERR_CLR,
  output logic       BUSY,
  sh7034_sci_xfer_ctrl_if.master bus
);

  localparam logic [27:0] BASE = SCI_BASE + 28'(N * 8);

  scxc_state_t state_reg, state_next;
  ibus_acc_t   acc_reg, acc_next;
  logic        req_reg, req_next;
  logic [2:0]  err_reg, err_next;
  logic [2:0]  err_set;
  logic        tx_first_reg, tx_first_next;
  logic        tx_pop;
  logic        rx_push;
  logic        rx_full;
  logic [7:0]  tx_head;
  logic [7:0]  rd_byte;
  logic        unused_ok;

  // The SCI replicates its byte on every lane, so reads always use the top lane.
  assign rd_byte   = bus.IBUS_DI[31:24];
  assign unused_ok = &{1'b0, CE_F, bus.IBUS_DI[23:0]};

  sh7034_sci_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE_R),
    .PUSH  (TX_PUSH),
    .WDATA (TX_DATA),
    .POP   (tx_pop),
    .RDATA (tx_head),
    .FULL  (TX_FULL),
    .EMPTY (TX_EMPTY)
  );

  sh7034_sci_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE_R),
    .PUSH  (rx_push),
    .WDATA (rd_byte),
    .POP   (RX_POP),
    .RDATA (RX_DATA),
    .FULL  (rx_full),
    .EMPTY (RX_EMPTY)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_OFF;
      acc_reg      <= '0;
      req_reg      <= 1'b0;
      err_reg      <= 3'b000;
      tx_first_reg <= 1'b0;
    end else if (CE_R) begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      req_reg      <= req_next;
      err_reg      <= err_next;
      tx_first_reg <= tx_first_next;
    end
  end

  // In each state the access registered on entry completes here; the branch
  // consumes its result and registers the next access, if any.
  always_comb begin
    state_next    = state_reg;
    acc_next      = '0;
    req_next      = 1'b0;
    err_set       = 3'b000;
    tx_first_next = tx_first_reg;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;

    unique case (state_reg)
      ST_OFF: begin
        if (EN) begin
          state_next = ST_INIT_SMR;
          acc_next   = sci_access(BASE, OFS_SMR, 1'b1, SMR_VAL);
          req_next   = 1'b1;
        end
      end
      ST_INIT_SMR: begin
        state_next = ST_INIT_BRR;
        acc_next   = sci_access(BASE, OFS_BRR, 1'b1, BRR_VAL);
        req_next   = 1'b1;
      end
      ST_INIT_BRR: begin
        state_next = ST_INIT_SCR;
        acc_next   = sci_access(BASE, OFS_SCR, 1'b1, SCR_RUN);
        req_next   = 1'b1;
      end
      ST_INIT_SCR: begin
        // TXI only fires on a TDRE edge, so the first byte must be kicked off
        // without waiting for it.
        state_next    = ST_IDLE;
        tx_first_next = 1'b1;
      end
      ST_IDLE: begin
        if (bus.ERI_IRQ) begin
          state_next = ST_E_RD;
          acc_next   = sci_access(BASE, OFS_SSR, 1'b0, 8'h00);
          req_next   = 1'b1;
        end else if (bus.RXI_IRQ && !rx_full) begin
          // With the RX FIFO full the SCI is left to overrun; ORER is then
          // picked up on the error path and no queued byte is displaced.
          state_next = ST_R_RD;
          acc_next   = sci_access(BASE, OFS_SSR, 1'b0, 8'h00);
          req_next   = 1'b1;
        end else if (!TX_EMPTY && (bus.TXI_IRQ || tx_first_reg)) begin
          state_next = ST_T_RD;
          acc_next   = sci_access(BASE, OFS_SSR, 1'b0, 8'h00);
          req_next   = 1'b1;
        end
      end
      ST_T_RD: begin
        if (rd_byte[SSR_TDRE]) begin
          state_next = ST_T_WR;
          acc_next   = sci_access(BASE, OFS_TDR, 1'b1, tx_head);
          req_next   = 1'b1;
          tx_pop     = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_T_WR: begin
        state_next = ST_T_CLR;
        acc_next   = sci_access(BASE, OFS_SSR, 1'b1, SSR_CLR_TX);
        req_next   = 1'b1;
      end
      ST_T_CLR: begin
        state_next    = ST_IDLE;
        tx_first_next = 1'b0;
      end
      ST_R_RD: begin
        if (rd_byte[SSR_RDRF]) begin
          state_next = ST_R_DAT;
          acc_next   = sci_access(BASE, OFS_RDR, 1'b0, 8'h00);
          req_next   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_R_DAT: begin
        rx_push    = 1'b1;
        state_next = ST_R_CLR;
        acc_next   = sci_access(BASE, OFS_SSR, 1'b1, SSR_CLR_RX);
        req_next   = 1'b1;
      end
      ST_R_CLR: begin
        state_next = ST_IDLE;
      end
      ST_E_RD: begin
        err_set    = {rd_byte[SSR_ORER], rd_byte[SSR_FER], rd_byte[SSR_PER]};
        state_next = ST_E_CLR;
        acc_next   = sci_access(BASE, OFS_SSR, 1'b1, SSR_CLR_ERR);
        req_next   = 1'b1;
      end
      ST_E_CLR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase

    // Disable: the access completing now keeps its effect, nothing further is
    // issued. A TDRE-ready read does not pop, so no byte is lost there.
    if (!EN && state_reg != ST_OFF) begin
      state_next = ST_OFF;
      acc_next   = '0;
      req_next   = 1'b0;
      tx_pop     = 1'b0;
    end

    err_next = (ERR_CLR ? 3'b000 : err_reg) | err_set;
  end

  assign bus.IBUS_A   = acc_reg.addr;
  assign bus.IBUS_DO  = acc_reg.wdata;
  assign bus.IBUS_BA  = acc_reg.lanes;
  assign bus.IBUS_WE  = acc_reg.we;
  assign bus.IBUS_REQ = req_reg;
  assign ERR          = err_reg;
  assign BUSY         = !(state_reg inside {ST_OFF, ST_IDLE});

endmodule

// File: tb/tb_sh7034_sci_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sh7034_sci_xfer_ctrl
//   Directed bench: the initial block plays the SCI (read data, IRQ lines)
//   and checks every bus window against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sh7034_sci_xfer_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CE_R;
  logic       CE_F;
  logic       EN;
  logic [7:0] TX_DATA;
  logic       TX_PUSH;
  logic       TX_FULL;
  logic       TX_EMPTY;
  logic [7:0] RX_DATA;
  logic       RX_POP;
  logic       RX_EMPTY;
  logic [2:0] ERR;
  logic       ERR_CLR;
  logic       BUSY;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [27:0] A_SMR = 28'h5FFFEC0;
  localparam logic [27:0] A_BRR = 28'h5FFFEC1;
  localparam logic [27:0] A_SCR = 28'h5FFFEC2;
  localparam logic [27:0] A_TDR = 28'h5FFFEC3;
  localparam logic [27:0] A_SSR = 28'h5FFFEC4;
  localparam logic [27:0] A_RDR = 28'h5FFFEC5;

  sh7034_sci_xfer_ctrl_if bus ();

  sh7034_sci_xfer_ctrl #(
    .N       (0),
    .DEPTH   (4),
    .SMR_VAL (8'h12),
    .BRR_VAL (8'h34)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .CE_F     (CE_F),
    .EN       (EN),
    .TX_DATA  (TX_DATA),
    .TX_PUSH  (TX_PUSH),
    .TX_FULL  (TX_FULL),
    .TX_EMPTY (TX_EMPTY),
    .RX_DATA  (RX_DATA),
    .RX_POP   (RX_POP),
    .RX_EMPTY (RX_EMPTY),
    .ERR      (ERR),
    .ERR_CLR  (ERR_CLR),
    .BUSY     (BUSY),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] bx(input logic [27:0] a, input logic [31:0] d,
                                     input logic [3:0] ba, input logic we, input logic req);
    return {30'd0, a, d, ba, we, req};
  endfunction

  task automatic chk_bus(input string tag, input logic [95:0] exp);
    chk(tag, bx(bus.IBUS_A, bus.IBUS_DO, bus.IBUS_BA, bus.IBUS_WE, bus.IBUS_REQ), exp);
  endtask

  initial begin
    logic [95:0] idle_b, rd_ssr;
    logic [7:0]  b;
    logic [7:0]  exp_rx [4];

    idle_b = bx(28'd0, 32'd0, 4'b0000, 1'b0, 1'b0);
    rd_ssr = bx(A_SSR, 32'd0, 4'b1000, 1'b0, 1'b1);
    exp_rx[0] = 8'h3C; exp_rx[1] = 8'h11; exp_rx[2] = 8'h22; exp_rx[3] = 8'h33;

    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0; EN = 1'b0;
    TX_DATA = 8'h00; TX_PUSH = 1'b0; RX_POP = 1'b0; ERR_CLR = 1'b0;
    bus.IBUS_DI = 32'd0; bus.TXI_IRQ = 1'b0; bus.RXI_IRQ = 1'b0; bus.ERI_IRQ = 1'b0;

    // Reset state
    tick(); tick();
    chk_bus("rst_bus", idle_b);
    chk("rst_err", 96'(ERR), 96'(3'b000));
    chk("rst_busy", 96'(BUSY), 96'(1'b0));
    chk("rst_fifo_flags", 96'({TX_EMPTY, TX_FULL, RX_EMPTY}), 96'(3'b101));
    RST_N = 1'b1;
    tick();

    // Nothing advances without CE_R
    CE_R = 1'b0; TX_PUSH = 1'b1; TX_DATA = 8'h11; EN = 1'b1;
    tick(); tick();
    chk("ce_gate", 96'({TX_EMPTY, BUSY, bus.IBUS_REQ}), 96'(3'b100));
    TX_PUSH = 1'b0; CE_R = 1'b1;

    // Init: SMR, BRR, SCR on consecutive windows
    tick(); chk_bus("init_smr", bx(A_SMR, 32'h1200_0000, 4'b1000, 1'b1, 1'b1));
    chk("init_busy", 96'(BUSY), 96'(1'b1));
    tick(); chk_bus("init_brr", bx(A_BRR, 32'h0034_0000, 4'b0100, 1'b1, 1'b1));
    tick(); chk_bus("init_scr", bx(A_SCR, 32'h0000_F000, 4'b0010, 1'b1, 1'b1));
    tick(); chk_bus("init_idle", idle_b);
    chk("idle_busy", 96'(BUSY), 96'(1'b0));

    // TX: first byte goes without TXI
    TX_PUSH = 1'b1; TX_DATA = 8'h55;
    tick(); chk("tx_push1", 96'(TX_EMPTY), 96'(1'b0));
    chk_bus("tx_wait_push", idle_b);
    TX_DATA = 8'hAA;
    tick(); TX_PUSH = 1'b0; chk_bus("tx1_rd", rd_ssr);
    bus.IBUS_DI = 32'h8484_8484;
    tick(); chk_bus("tx1_tdr", bx(A_TDR, 32'h0000_0055, 4'b0001, 1'b1, 1'b1));
    tick(); chk_bus("tx1_clr", bx(A_SSR, 32'h7E00_0000, 4'b1000, 1'b1, 1'b1));
    tick(); chk_bus("tx1_idle", idle_b);
    tick(); chk_bus("tx_first_cleared", idle_b);

    // TX: TDRE=0 -> back to IDLE, nothing popped; retry succeeds
    bus.TXI_IRQ = 1'b1; bus.IBUS_DI = 32'h0404_0404;
    tick(); chk_bus("tx2_rd_busy", rd_ssr);
    tick(); chk_bus("tx2_tdre0", idle_b);
    chk("tx2_not_popped", 96'(TX_EMPTY), 96'(1'b0));
    bus.IBUS_DI = 32'h8484_8484;
    tick(); chk_bus("tx2_rd", rd_ssr);
    tick(); bus.TXI_IRQ = 1'b0;
    chk_bus("tx2_tdr", bx(A_TDR, 32'h0000_00AA, 4'b0001, 1'b1, 1'b1));
    tick(); chk_bus("tx2_clr", bx(A_SSR, 32'h7E00_0000, 4'b1000, 1'b1, 1'b1));
    tick(); chk("tx_drained", 96'(TX_EMPTY), 96'(1'b1));

    // RX: one byte 3C
    bus.RXI_IRQ = 1'b1;
    tick(); chk_bus("rx_rd", rd_ssr);
    bus.IBUS_DI = 32'h4040_4040;
    tick(); chk_bus("rx_rdr", bx(A_RDR, 32'd0, 4'b0100, 1'b0, 1'b1));
    bus.IBUS_DI = 32'h3C3C_3C3C;
    tick(); chk_bus("rx_clr", bx(A_SSR, 32'hBE00_0000, 4'b1000, 1'b1, 1'b1));
    chk("rx_data", 96'({RX_EMPTY, RX_DATA}), 96'({1'b0, 8'h3C}));
    bus.RXI_IRQ = 1'b0;
    tick(); chk_bus("rx_idle", idle_b);

    // Fill the RX FIFO (depth 4)
    for (int i = 1; i <= 3; i++) begin
      b = 8'(8'h11 * i);
      bus.RXI_IRQ = 1'b1;
      tick();
      bus.IBUS_DI = 32'h4040_4040;
      tick();
      bus.IBUS_DI = {4{b}};
      tick();
      bus.RXI_IRQ = 1'b0;
      tick();
    end

    // Overrun: RXI ignored while full, ERI records ORER
    bus.RXI_IRQ = 1'b1;
    tick(); chk_bus("rx_full_hold", idle_b);
    bus.ERI_IRQ = 1'b1;
    tick(); chk_bus("ovr_e_rd", rd_ssr);
    bus.ERI_IRQ = 1'b0; bus.IBUS_DI = 32'h6060_6060;
    tick(); chk_bus("ovr_e_clr", bx(A_SSR, 32'hC600_0000, 4'b1000, 1'b1, 1'b1));
    chk("ovr_err", 96'(ERR), 96'(3'b100));
    tick(); tick(); chk_bus("ovr_no_rdr", idle_b);
    bus.RXI_IRQ = 1'b0;

    // Drain RX FIFO in order
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rx_pop%0d", i), 96'({RX_EMPTY, RX_DATA}), 96'({1'b0, exp_rx[i]}));
      RX_POP = 1'b1;
      tick();
      RX_POP = 1'b0;
    end
    chk("rx_drained", 96'(RX_EMPTY), 96'(1'b1));

    // Priority: ERI, RXI and pending TX together
    TX_PUSH = 1'b1; TX_DATA = 8'h77;
    tick(); TX_PUSH = 1'b0; chk_bus("prio_wait", idle_b);
    bus.ERI_IRQ = 1'b1; bus.RXI_IRQ = 1'b1; bus.TXI_IRQ = 1'b1;
    tick(); chk_bus("prio_e_rd", rd_ssr);
    bus.ERI_IRQ = 1'b0; bus.IBUS_DI = 32'h1010_1010; ERR_CLR = 1'b1;
    tick(); ERR_CLR = 1'b0;
    chk_bus("prio_e_clr", bx(A_SSR, 32'hC600_0000, 4'b1000, 1'b1, 1'b1));
    chk("err_set_wins", 96'(ERR), 96'(3'b010));
    tick(); chk_bus("prio_idle1", idle_b);
    tick(); chk_bus("prio_r_rd", rd_ssr);
    bus.IBUS_DI = 32'h4040_4040;
    tick(); chk_bus("prio_r_dat", bx(A_RDR, 32'd0, 4'b0100, 1'b0, 1'b1));
    bus.IBUS_DI = 32'h9999_9999;
    tick(); chk_bus("prio_r_clr", bx(A_SSR, 32'hBE00_0000, 4'b1000, 1'b1, 1'b1));
    bus.RXI_IRQ = 1'b0;
    tick(); chk_bus("prio_idle2", idle_b);
    tick(); chk_bus("prio_t_rd", rd_ssr);
    bus.IBUS_DI = 32'h8080_8080;
    tick(); chk_bus("prio_t_wr", bx(A_TDR, 32'h0000_0077, 4'b0001, 1'b1, 1'b1));

    // Abort during T_WR: write completes, no SSR clear follows
    EN = 1'b0; bus.TXI_IRQ = 1'b0;
    tick(); chk_bus("abort_off", idle_b);
    chk("abort_busy", 96'(BUSY), 96'(1'b0));
    tick(); chk_bus("abort_no_clr", idle_b);
    chk("abort_tx_empty", 96'(TX_EMPTY), 96'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
